// File: rtl/matrix_receiver.sv
// Receives a six-matrix frame into shadow slots and commits all six together on end-of-frame.
// Optional order checking is enabled by defining MATRIX_RX_SEQ_CHECK_EN.
module matrix_receiver #(
    parameter int SAMPLE_DLY = 3
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         CPUvalid,
    input  logic [3:0]   matrixState,
    input  logic [335:0] mtrxIn,
    output logic [335:0] inMtrx_q,
    output logic [335:0] rotXMtrx_q,
    output logic [335:0] rotYMtrx_q,
    output logic [335:0] rotZMtrx_q,
    output logic [335:0] shiftMtrx_q,
    output logic [335:0] projMtrx_q,
    output logic [5:0]   capMask,
    output logic         frameDone,
    output logic         frameValid,
    output logic         seqErr,
    output logic [7:0]   frameCnt,
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     prev_tag;
    logic [2:0]     stab_cnt;
    logic [335:0]   shadow [6];

    logic           tag_change;
    logic [2:0]     cnt_next;
    logic           capture_hit;
    logic           seq_bad;

    assign fsm_state = state;

    // Counter value after this edge: number of extra edges the tag has been stable.
    always_comb begin
        tag_change  = (matrixState != prev_tag);
        cnt_next    = tag_change ? 3'd0 : ((stab_cnt == 3'd7) ? 3'd7 : stab_cnt + 3'd1);
        capture_hit = (cnt_next == 3'(SAMPLE_DLY - 1)) &&
                      (matrixState >= 4'd1) && (matrixState <= 4'd6);
    end

    always_comb begin
        seq_bad = 1'b0;
`ifdef MATRIX_RX_SEQ_CHECK_EN
        if (tag_change) begin
            if (matrixState != prev_tag + 4'd1)
                seq_bad = 1'b1;
            for (int k = 0; k < 6; k++)
                if (prev_tag == 4'(k + 1) && !capMask[k])
                    seq_bad = 1'b1;
        end
`endif
    end

`ifdef MATRIX_RX_SEQ_CHECK_EN
    logic seq_err_q;
    assign seqErr = seq_err_q;
`else
    assign seqErr = 1'b0;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev_tag    <= 4'd0;
            stab_cnt    <= 3'd0;
            capMask     <= 6'd0;
            frameDone   <= 1'b0;
            frameValid  <= 1'b0;
            frameCnt    <= 8'd0;
            inMtrx_q    <= '0;
            rotXMtrx_q  <= '0;
            rotYMtrx_q  <= '0;
            rotZMtrx_q  <= '0;
            shiftMtrx_q <= '0;
            projMtrx_q  <= '0;
            for (int k = 0; k < 6; k++)
                shadow[k] <= '0;
`ifdef MATRIX_RX_SEQ_CHECK_EN
            seq_err_q   <= 1'b0;
`endif
        end else begin
            frameDone <= 1'b0;
            prev_tag  <= matrixState;
            stab_cnt  <= cnt_next;
            case (state)
                IDLE: begin
                    if (CPUvalid && matrixState == 4'd1) begin
                        state    <= RECV;
                        capMask  <= 6'd0;
                        stab_cnt <= 3'd0;
`ifdef MATRIX_RX_SEQ_CHECK_EN
                        seq_err_q <= 1'b0;
`endif
                    end
                end
                RECV: begin
                    if (!CPUvalid) begin
                        state   <= IDLE;
                        capMask <= 6'd0;
                    end else if (seq_bad) begin
`ifdef MATRIX_RX_SEQ_CHECK_EN
                        seq_err_q <= 1'b1;
`endif
                        state <= HOLD;
                    end else if (matrixState == 4'd8) begin
                        // Commit only a complete frame; the bank is updated as a whole.
                        if (capMask == 6'h3F) begin
                            inMtrx_q    <= shadow[0];
                            rotXMtrx_q  <= shadow[1];
                            rotYMtrx_q  <= shadow[2];
                            rotZMtrx_q  <= shadow[3];
                            shiftMtrx_q <= shadow[4];
                            projMtrx_q  <= shadow[5];
                            frameDone   <= 1'b1;
                            frameValid  <= 1'b1;
                            frameCnt    <= frameCnt + 8'd1;
                        end
                        state <= HOLD;
                    end else if (capture_hit) begin
                        for (int k = 0; k < 6; k++) begin
                            if (matrixState == 4'(k + 1)) begin
                                shadow[k]  <= mtrxIn;
                                capMask[k] <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!CPUvalid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_receiver.sv
// Randomized and directed frame-level bench for matrix_receiver with a frame-outcome model.
module tb_matrix_receiver;
  localparam int SAMPLE_DLY = 3;

  logic         CLK = 1'b0;
  logic         rst_n;
  logic         CPUvalid;
  logic [3:0]   matrixState;
  logic [335:0] mtrxIn;
  logic [335:0] inMtrx_q, rotXMtrx_q, rotYMtrx_q, rotZMtrx_q, shiftMtrx_q, projMtrx_q;
  logic [5:0]   capMask;
  logic         frameDone, frameValid, seqErr;
  logic [7:0]   frameCnt;
  logic [1:0]   fsm_state;

  matrix_receiver #(.SAMPLE_DLY(SAMPLE_DLY)) dut (
    .CLK(CLK), .rst_n(rst_n), .CPUvalid(CPUvalid), .matrixState(matrixState), .mtrxIn(mtrxIn),
    .inMtrx_q(inMtrx_q), .rotXMtrx_q(rotXMtrx_q), .rotYMtrx_q(rotYMtrx_q),
    .rotZMtrx_q(rotZMtrx_q), .shiftMtrx_q(shiftMtrx_q), .projMtrx_q(projMtrx_q),
    .capMask(capMask), .frameDone(frameDone), .frameValid(frameValid), .seqErr(seqErr),
    .frameCnt(frameCnt), .fsm_state(fsm_state)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [335:0] exp_bank [6];
  logic [335:0] cap_data [6];
  logic [7:0]   exp_cnt;
  bit           exp_valid;

  int           seg_tag  [16];
  int           seg_hold [16];
  logic [335:0] seg_data [16];

  task automatic check(input string name, input logic [335:0] obs, input logic [335:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_bank();
    check("inMtrx_q",    inMtrx_q,    exp_bank[0]);
    check("rotXMtrx_q",  rotXMtrx_q,  exp_bank[1]);
    check("rotYMtrx_q",  rotYMtrx_q,  exp_bank[2]);
    check("rotZMtrx_q",  rotZMtrx_q,  exp_bank[3]);
    check("shiftMtrx_q", shiftMtrx_q, exp_bank[4]);
    check("projMtrx_q",  projMtrx_q,  exp_bank[5]);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [335:0] rand_payload();
    logic [351:0] v;
    for (int w = 0; w < 11; w++) v[w*32 +: 32] = $urandom;
    return v[335:0];
  endfunction

  function automatic logic [335:0] byte_payload(input int k);
    logic [335:0] v;
    for (int b = 0; b < 42; b++) v[b*8 +: 8] = 8'(k);
    return v;
  endfunction

  task automatic set_seg(input int i, input int t, input int h, input logic [335:0] d);
    seg_tag[i]  = t;
    seg_hold[i] = h;
    seg_data[i] = d;
  endtask

  // Drives one frame then drops CPUvalid; the model tracks frame-level outcome.
  task automatic run_frame(input int nseg);
    logic [5:0] m;
    bit err, done, commit;
    int pulses, t, p;
    m = 6'd0; err = 0; done = 0; commit = 0; pulses = 0;
    for (int i = 0; i < nseg; i++) begin
      t = seg_tag[i];
      for (int j = 1; j <= seg_hold[i]; j++) begin
        CPUvalid = 1'b1; matrixState = 4'(t); mtrxIn = seg_data[i];
        tick();
        pulses += int'(frameDone);
        if (j == 1 && i > 0 && !done) begin
          p = seg_tag[i-1];
`ifdef MATRIX_RX_SEQ_CHECK_EN
          if (t != p + 1 || (p >= 1 && p <= 6 && seg_hold[i-1] < SAMPLE_DLY)) begin
            err = 1; done = 1;
          end
`endif
          if (!done && t == 8) begin
            done = 1;
            commit = (m == 6'h3F);
            if (commit) begin
              for (int k = 0; k < 6; k++) exp_bank[k] = cap_data[k];
              exp_cnt++;
              exp_valid = 1;
            end
            check("frameDone_at_eof", 336'(frameDone), 336'(commit));
            check("frameCnt_at_eof", 336'(frameCnt), 336'(exp_cnt));
          end
        end else if (!done && j == SAMPLE_DLY && t >= 1 && t <= 6) begin
          m[t-1] = 1'b1;
          cap_data[t-1] = seg_data[i];
        end
        check("capMask", 336'(capMask), 336'(m));
        check("seqErr", 336'(seqErr), 336'(err));
      end
    end
    CPUvalid = 1'b0; matrixState = 4'd0; mtrxIn = '0;
    tick();
    pulses += int'(frameDone);
    if (!done) m = 6'd0;
    check("capMask_after_drop", 336'(capMask), 336'(m));
    tick();
    pulses += int'(frameDone);
    check("frameDone_pulses", 336'(pulses), 336'(commit));
    check("frameCnt", 336'(frameCnt), 336'(exp_cnt));
    check("frameValid", 336'(frameValid), 336'(exp_valid));
    check("seqErr_end", 336'(seqErr), 336'(err));
    check_bank();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; CPUvalid = 1'b0; matrixState = 4'd0; mtrxIn = '0;
    for (int k = 0; k < 6; k++) exp_bank[k] = '0;
    exp_cnt = 8'd0; exp_valid = 0;
    repeat (2) tick();
    check("rst_capMask", 336'(capMask), 336'(0));
    check("rst_frameDone", 336'(frameDone), 336'(0));
    check("rst_frameValid", 336'(frameValid), 336'(0));
    check("rst_seqErr", 336'(seqErr), 336'(0));
    check("rst_frameCnt", 336'(frameCnt), 336'(0));
    check_bank();
    rst_n = 1'b1;
    repeat (2) tick();

    // Stock frame: payload {42{8'hk}}, each tag held 7 cycles, including the gap tag.
    for (int i = 0; i < 8; i++) set_seg(i, i + 1, 7, byte_payload(i + 1));
    run_frame(8);

    // Random frames with varied hold lengths.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) set_seg(i, i + 1, $urandom_range(3, 7), rand_payload());
      run_frame(8);
    end

    // Abort while tag 4 is active.
    for (int i = 0; i < 4; i++) set_seg(i, i + 1, (i == 3) ? 2 : 7, rand_payload());
    run_frame(4);

    // Skipped tag 3: 1,2,4,5,6,7,8.
    set_seg(0, 1, 5, rand_payload());
    set_seg(1, 2, 5, rand_payload());
    for (int i = 2; i < 7; i++) set_seg(i, i + 2, 5, rand_payload());
    run_frame(7);
`ifndef MATRIX_RX_SEQ_CHECK_EN
    check("skip_capMask_3B", 336'(capMask), 336'(6'h3B));
`endif

    // Tag 3 held only two cycles.
    for (int i = 0; i < 8; i++) set_seg(i, i + 1, (i == 2) ? 2 : 5, rand_payload());
    run_frame(8);
    check("short_hold_bit_clear", 336'(capMask[2]), 336'(0));

    // Asynchronous reset pulse in the middle of a frame.
    CPUvalid = 1'b1; matrixState = 4'd1; mtrxIn = rand_payload();
    repeat (4) tick();
    matrixState = 4'd2;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) exp_bank[k] = '0;
    exp_cnt = 8'd0; exp_valid = 0;
    check("async_capMask", 336'(capMask), 336'(0));
    check("async_frameCnt", 336'(frameCnt), 336'(0));
    check("async_frameValid", 336'(frameValid), 336'(0));
    check("async_seqErr", 336'(seqErr), 336'(0));
    check("async_frameDone", 336'(frameDone), 336'(0));
    check_bank();
    tick();
    rst_n = 1'b1;
    // Mid-frame tags after reset must not be captured while waiting for tag 1.
    matrixState = 4'd2;
    repeat (4) tick();
    check("post_rst_idle_capMask", 336'(capMask), 336'(0));
    CPUvalid = 1'b0; matrixState = 4'd0;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) set_seg(i, i + 1, 4, rand_payload());
    run_frame(8);

    // Long run to wrap frameCnt through 255 -> 0.
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 8; i++) set_seg(i, i + 1, $urandom_range(3, 4), rand_payload());
      seg_hold[6] = 1;
      seg_hold[7] = 1;
      run_frame(8);
    end
    check("frameCnt_after_wrap", 336'(frameCnt), 336'(8'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
